// File: rtl/noc_flit_pkg.sv
// Flit-type encoding, arbitration policy codes and flit field layout shared by
// the wormhole node, its input buffers, route stage and output allocators.
package noc_flit_pkg;

    typedef logic [1:0] flit_id_t;

    localparam flit_id_t HEAD   = 2'b10;
    localparam flit_id_t BODY   = 2'b00;
    localparam flit_id_t TAIL   = 2'b01;
    localparam flit_id_t SINGLE = 2'b11;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Flit layout: payload in the low bits, type field directly above it.
    localparam int FLIT_DATA_W = 32;
    localparam int FLIT_ID_LSB = FLIT_DATA_W;
    localparam int FLIT_W      = FLIT_DATA_W + $bits(flit_id_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_t;

    // Bit 1 marks packet start, bit 0 marks packet end (SINGLE has both).
    function automatic logic is_head(input flit_id_t f);
        return f[1];
    endfunction

    function automatic logic is_tail(input flit_id_t f);
        return f[0];
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// One-hot request arbiter, round-robin from ptr_i upward with wrap, or fixed
// lowest-index priority. Purely combinational, zero latency, no backpressure.
module rr_arbiter_onehot
    import noc_flit_pkg::*;
#(
    parameter int IN_N     = 5,
    parameter int ARB_TYPE = ARB_RR
) (
    input  logic [IN_N-1:0]         req_i,
    input  logic [$clog2(IN_N)-1:0] ptr_i,
    output logic [IN_N-1:0]         gnt_o,
    output logic                    vld_o
);

    int   start;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        start = (ARB_TYPE == ARB_FIXED) ? 0 : int'(ptr_i);
        // Visit candidates in priority order; the first requester wins.
        for (int k = 0; k < IN_N; k++) begin
            for (int i = 0; i < IN_N; i++) begin
                if (!found && req_i[i] && (((start + k) % IN_N) == i)) begin
                    gnt_o[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        vld_o = |req_i;
    end

endmodule

// File: rtl/wormhole_output_allocator.sv
// Per-output switch allocator: grants one input from head to tail, grant one cycle
// after the head request; pops stall while out_rdy_i is low, grant is held.
module wormhole_output_allocator
    import noc_flit_pkg::*;
#(
    parameter int IN_N      = 5,
    parameter int FLIT_ID_W = 2,
    parameter int ARB_TYPE  = ARB_RR
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [IN_N-1:0]           req_i,
    input  logic [IN_N*FLIT_ID_W-1:0] flit_id_i,
    input  logic                      out_rdy_i,
    output logic [IN_N-1:0]           grant_o,
    output logic [IN_N-1:0]           pop_o,
    output logic                      out_vld_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int PTR_W = $clog2(IN_N);

    alloc_state_t     state_q, state_d;
    logic [IN_N-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             first_done_q, first_done_d;

    logic [IN_N-1:0]  eligible;
    logic [IN_N-1:0]  bad_head;
    logic [IN_N-1:0]  arb_gnt;
    logic             arb_vld;
    flit_id_t         owner_fid;
    logic [PTR_W-1:0] owner_idx;
    logic             owner_req;
    logic             xfer;

    always_comb begin : decode
        eligible  = '0;
        bad_head  = '0;
        owner_fid = BODY;
        owner_idx = '0;
        for (int i = 0; i < IN_N; i++) begin
            eligible[i] = req_i[i] & is_head(flit_id_i[i*FLIT_ID_W +: FLIT_ID_W]);
            bad_head[i] = req_i[i] & ~is_head(flit_id_i[i*FLIT_ID_W +: FLIT_ID_W]);
            if (owner_q[i]) begin
                owner_fid = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
                owner_idx = PTR_W'(i);
            end
        end
        owner_req = |(req_i & owner_q);
        xfer      = owner_req & out_rdy_i;
    end

    rr_arbiter_onehot #(
        .IN_N     (IN_N),
        .ARB_TYPE (ARB_TYPE)
    ) u_arb (
        .req_i (eligible),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .vld_o (arb_vld)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            first_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            first_done_q <= first_done_d;
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        first_done_d = first_done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d      = ST_LOCKED;
                    owner_d      = arb_gnt;
                    first_done_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                // Owner bubbles leave the lock in place; only a tail releases it.
                if (xfer) begin
                    first_done_d = 1'b1;
                    if (is_tail(owner_fid)) begin
                        state_d  = ST_IDLE;
                        owner_d  = '0;
                        rr_ptr_d = (owner_idx == PTR_W'(IN_N - 1)) ? '0 : owner_idx + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : outputs
        grant_o   = owner_q;
        pop_o     = owner_q & req_i & {IN_N{out_rdy_i}};
        out_vld_o = owner_req;
        busy_o    = (state_q == ST_LOCKED);
        if (state_q == ST_IDLE) begin
            err_o = |bad_head;
        end else begin
            // A second HEAD inside a locked packet is flagged but still forwarded.
            err_o = first_done_q & owner_req & (owner_fid == HEAD);
        end
    end

endmodule
